// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the two requesters (A = ALU, B = load), the arbiter and the register file.
// The master modport is the requester/register-file side; the slave modport is the arbiter side.
interface rf_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;

    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;

    logic              write_enabled;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              last_grant;

    modport master (
        output a_valid, a_addr, a_data,
        input  a_ready,
        output b_valid, b_addr, b_data,
        input  b_ready,
        input  write_enabled, write_addr, write_data, last_grant
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        output a_ready,
        input  b_valid, b_addr, b_data,
        output b_ready,
        output write_enabled, write_addr, write_data, last_grant
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Purpose: round-robin arbiter merging two writeback requesters onto one register file write port.
// Latency: 1 cycle from accepted handshake to write strobe; readies are combinational from valids/last_grant.
// Backpressure: loser of a tie sees ready=0 and must hold; no buffering. RF_WB_ZERO_FILTER_EN drops addr-0 writes.
module rf_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic         clock,
    input  logic         reset_n,
    rf_wb_arbiter_if.slave bus
);
    logic              grant_a;
    logic              grant_b;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              wr_en;

    logic              write_enabled_q;
    logic [ADDR_W-1:0] write_addr_q;
    logic [DATA_W-1:0] write_data_q;
    logic              last_grant_q;

    // last_grant_q = 1 means B won last, so A takes the next tie.
    always_comb begin
        grant_a  = reset_n && bus.a_valid && (!bus.b_valid || last_grant_q);
        grant_b  = reset_n && bus.b_valid && (!bus.a_valid || !last_grant_q);
        xfer     = grant_a || grant_b;
        sel_addr = grant_b ? bus.b_addr : bus.a_addr;
        sel_data = grant_b ? bus.b_data : bus.a_data;
`ifdef RF_WB_ZERO_FILTER_EN
        wr_en    = xfer && (sel_addr != '0);
`else
        wr_en    = xfer;
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_enabled_q <= 1'b0;
            write_addr_q    <= '0;
            write_data_q    <= '0;
            last_grant_q    <= 1'b1;
        end else begin
            write_enabled_q <= wr_en;
            if (xfer) begin
                write_addr_q <= sel_addr;
                write_data_q <= sel_data;
                last_grant_q <= grant_b;
            end
        end
    end

    assign bus.a_ready       = grant_a;
    assign bus.b_ready       = grant_b;
    assign bus.write_enabled = write_enabled_q;
    assign bus.write_addr    = write_addr_q;
    assign bus.write_data    = write_data_q;
    assign bus.last_grant    = last_grant_q;
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of write data.
REQ-002 Parameter ADDR_W, default 5, width of register address.
REQ-003 The block SHALL have one clock, clock, and an asynchronous active-low reset, reset_n.
REQ-004 Port clock  input  1  rising-edge clock for all state.
REQ-005 Port reset_n  input  1  asynchronous active-low reset.
REQ-006 Port a_valid  input  1  requester A (ALU writeback) holds a write.
REQ-007 Port a_addr  input  ADDR_W  requester A destination register.
REQ-008 Port a_data  input  DATA_W  requester A write value.
REQ-009 Port a_ready  output  1  requester A write accepted this cycle.
REQ-010 Ports b_valid, b_addr, b_data, b_ready SHALL mirror REQ-006..009 for requester B (load writeback).
REQ-011 Port write_enabled  output  1  register file write strobe.
REQ-012 Port write_addr  output  ADDR_W  register file write address.
REQ-013 Port write_data  output  DATA_W  register file write data.
REQ-014 Port last_grant  output  1  0 = A granted last, 1 = B granted last.

Function
REQ-015 A transfer SHALL occur on a rising edge where x_valid and x_ready are both 1.
REQ-016 a_ready and b_ready SHALL be combinational from valids and last_grant; at most one SHALL be 1 in any cycle.
REQ-017 Only one requester valid -> that requester's ready = 1 the same cycle.
REQ-018 Both valid -> grant the requester not named by last_grant (round-robin).
REQ-019 Neither valid -> both readies 0; last_grant unchanged.
REQ-020 On every transfer, last_grant SHALL update to the granted requester at the same edge.
REQ-021 write_enabled, write_addr, write_data SHALL be registered: a transfer at edge N drives them during cycle N..N+1 (latency 1).
REQ-022 With no transfer at an edge, write_enabled SHALL be 0 for the following cycle; write_addr/write_data SHALL hold their last values.
REQ-023 Requesters SHALL hold valid, addr and data stable until ready; the block does not buffer unaccepted requests.
REQ-024 Back-to-back transfers SHALL be sustained at one per cycle; continuous dual valid alternates A, B, A, B.
REQ-025 Same address from both requesters in consecutive cycles SHALL write in grant order; the later write wins.

Reset
REQ-026 Asserting reset_n low SHALL immediately force write_enabled = 0, write_addr = 0, write_data = 0, last_grant = 1 (A wins first tie).
REQ-027 a_ready and b_ready SHALL be 0 while reset_n is low.
REQ-028 Reset asserted mid-operation SHALL discard any registered write; no write_enabled pulse after reset deassertion without a new transfer.

Configuration
REQ-029 Macro RF_WB_ZERO_FILTER_EN defined -> a transfer with addr 0 SHALL complete the handshake and update last_grant, but write_enabled SHALL stay 0 for that cycle.
REQ-030 RF_WB_ZERO_FILTER_EN undefined -> addr 0 transfers SHALL be presented to the register file like any other address.

Verification
REQ-031 Reset, then a_valid = 1, a_addr = 3, a_data = 32'h11111111 for one cycle -> a_ready = 1; next cycle write_enabled = 1, write_addr = 3, write_data = 32'h11111111.
REQ-032 Both valid from reset (A: addr 4/32'hAAAAAAAA, B: addr 5/32'hBBBBBBBB), held until accepted -> A granted first, B next cycle; write_addr sequence 4, 5; last_grant ends at 1.
REQ-033 Both held valid for 6 cycles -> grants A, B, A, B, A, B; never both readies high.
REQ-034 b_valid = 1, b_addr = 0, b_data = 32'hDEADBEEF -> with macro: b_ready = 1, write_enabled stays 0; without macro: write_enabled = 1, write_addr = 0.
REQ-035 reset_n pulsed low the cycle after an accepted transfer -> write_enabled = 0 immediately, outputs 0, last_grant = 1, no write after release.
REQ-036 No valids for 10 cycles -> write_enabled = 0 throughout, last_grant unchanged.
